// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write bypass, busy scoreboard and self-clearing sweep
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  rsv_valid,
  input  logic [AW-1:0]         rsv_addr
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t             r_state;
  logic [AW-1:0]      r_clr_cnt;
  logic [XLEN-1:0]    r_regs [NREGS];
  logic [NREGS-1:0]   r_busy;
  assign ready = r_state == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_clr_cnt <= '0;
      r_busy <= '0;
    end else if (r_state == CLEAR) begin
      r_regs[r_clr_cnt] <= '0;
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == AW'(NREGS - 1)) r_state <= RUN;
    end else begin
      if (we && waddr != '0) begin
        r_regs[waddr] <= wdata;
        r_busy[waddr] <= 1'b0;
      end
      if (rsv_valid && rsv_addr != '0) r_busy[rsv_addr] <= 1'b1;
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    logic          w_byp;
    assign w_ra = raddr[i*AW +: AW];
    assign w_zero = !ready || w_ra == '0;
    assign w_byp = we && waddr == w_ra;
    assign rdata[i*XLEN +: XLEN] = w_zero ? '0 : w_byp ? wdata : r_regs[w_ra];
    assign rbusy[i] = w_zero || w_byp ? 1'b0 : r_busy[w_ra];
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: random and directed checks of two reg_file_sb configurations against a reference model
module tb_reg_file_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, we, rsv_valid;
  logic [4:0]  waddr, rsv_addr;
  logic [63:0] wdata;
  logic [4:0]  ra [3];
  logic        a_ready, b_ready;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic [191:0] b_rdata;
  logic [2:0]  b_rbusy;
  int n_chk = 0;
  int n_err = 0;
  logic [63:0] m_mem [2][32];
  bit          m_busy [2][32];
  int          m_since [2];
  reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) u_a (
    .clk(clk), .rst(rst), .ready(a_ready), .raddr({ra[1], ra[0]}),
    .rdata(a_rdata), .rbusy(a_rbusy), .we(we), .waddr(waddr),
    .wdata(wdata[31:0]), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr)
  );
  reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) u_b (
    .clk(clk), .rst(rst), .ready(b_ready), .raddr({ra[2][3:0], ra[1][3:0], ra[0][3:0]}),
    .rdata(b_rdata), .rbusy(b_rbusy), .we(we), .waddr(waddr[3:0]),
    .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr[3:0])
  );
  function automatic int nr(input int k);
    return k == 0 ? 32 : 16;
  endfunction
  function automatic logic [63:0] msk(input int k);
    return k == 0 ? 64'h0000_0000_FFFF_FFFF : '1;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int w, r;
      w = int'(waddr) % nr(k);
      r = int'(rsv_addr) % nr(k);
      if (rst) begin
        m_since[k] = 0;
        for (int j = 0; j < 32; j++) begin
          m_mem[k][j] = '0;
          m_busy[k][j] = 1'b0;
        end
      end else if (m_since[k] < nr(k)) begin
        m_since[k]++;
      end else begin
        if (we && w != 0) begin
          m_mem[k][w] = wdata & msk(k);
          m_busy[k][w] = 1'b0;
        end
        if (rsv_valid && r != 0) m_busy[k][r] = 1'b1;
      end
    end
  endtask
  task automatic exp_rd(input int k, input int p, output logic [63:0] d, output logic b);
    int a, w;
    a = int'(ra[p]) % nr(k);
    w = int'(waddr) % nr(k);
    if (m_since[k] < nr(k) || a == 0) begin
      d = '0;
      b = 1'b0;
    end else if (we && w == a) begin
      d = wdata & msk(k);
      b = 1'b0;
    end else begin
      d = m_mem[k][a];
      b = m_busy[k][a];
    end
  endtask
  task automatic compare_all();
    logic [63:0] d;
    logic b;
    check("a_ready", a_ready, m_since[0] >= 32);
    check("b_ready", b_ready, m_since[1] >= 16);
    for (int p = 0; p < 2; p++) begin
      exp_rd(0, p, d, b);
      check($sformatf("a_rdata%0d", p), a_rdata[p*32 +: 32], d);
      check($sformatf("a_rbusy%0d", p), a_rbusy[p], b);
    end
    for (int p = 0; p < 3; p++) begin
      exp_rd(1, p, d, b);
      check($sformatf("b_rdata%0d", p), b_rdata[p*64 +: 64], d);
      check($sformatf("b_rbusy%0d", p), b_rbusy[p], b);
    end
  endtask
  task automatic tick();
    #2;
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic rd_chk(input string tag, input logic [63:0] d, input logic b);
    #2;
    for (int p = 0; p < 3; p++) begin
      if (p < 2) begin
        check($sformatf("%s_a%0d_d", tag, p), a_rdata[p*32 +: 32], d & 64'hFFFF_FFFF);
        check($sformatf("%s_a%0d_b", tag, p), a_rbusy[p], b);
      end
      check($sformatf("%s_b%0d_d", tag, p), b_rdata[p*64 +: 64], d);
      check($sformatf("%s_b%0d_b", tag, p), b_rbusy[p], b);
    end
  endtask
  task automatic set_ra(input logic [4:0] a);
    for (int p = 0; p < 3; p++) ra[p] = a;
  endtask
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 30) check({tag, "_early"}, a_ready, 1'b0);
    end
    check({tag, "_ready"}, a_ready, 1'b1);
  endtask
  initial begin
    rst = 1'b1; we = 1'b0; rsv_valid = 1'b0; waddr = '0; rsv_addr = '0; wdata = '0;
    set_ra(5'd0);
    @(posedge clk);
    model_update();
    #1;
    tick();
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 64'hDEAD; ra[0] = 5'd5;
    sweep("sweep");
    we = 1'b0;
    #2;
    check("x5_cleared", a_rdata[31:0], 64'h0);
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 64'h1234_5678; set_ra(5'd0);
    tick();
    we = 1'b0; set_ra(5'd7);
    rd_chk("x7", 64'h1234_5678, 1'b0);
    tick();
    we = 1'b1; waddr = 5'd0; wdata = '1; set_ra(5'd0);
    rd_chk("x0", 64'h0, 1'b0);
    tick();
    waddr = 5'd3; wdata = 64'hA5A5_A5A5_A5A5_A5A5; set_ra(5'd3);
    rd_chk("byp3", 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    tick();
    we = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd9; set_ra(5'd9);
    tick();
    rsv_valid = 1'b0;
    rd_chk("rsv9_1", 64'h0, 1'b1);
    tick();
    rd_chk("rsv9_2", 64'h0, 1'b1);
    tick();
    we = 1'b1; waddr = 5'd9; wdata = 64'h42;
    rd_chk("wr9_byp", 64'h42, 1'b0);
    tick();
    we = 1'b0;
    rd_chk("wr9_after", 64'h42, 1'b0);
    tick();
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    tick();
    we = 1'b1; waddr = 5'd4; wdata = 64'h77;
    tick();
    we = 1'b0; rsv_valid = 1'b0; set_ra(5'd4);
    rd_chk("wr_rsv4", 64'h77, 1'b1);
    tick();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 99) == 0;
      we = $urandom_range(0, 1);
      waddr = 5'($urandom);
      wdata = {$urandom, $urandom};
      rsv_valid = $urandom_range(0, 2) == 0;
      rsv_addr = 5'($urandom);
      for (int p = 0; p < 3; p++) ra[p] = $urandom_range(0, 3) == 0 ? waddr : 5'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      we = $urandom_range(0, 1); waddr = 5'($urandom); wdata = {$urandom, $urandom};
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0;
    sweep("mid_rst");
    for (int i = 0; i < 200; i++) begin
      we = $urandom_range(0, 1);
      waddr = 5'($urandom);
      wdata = {$urandom, $urandom};
      rsv_valid = $urandom_range(0, 1);
      rsv_addr = 5'($urandom);
      for (int p = 0; p < 3; p++) ra[p] = 5'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
